// File: rtl/bch_pkg.sv
// Shared definitions for the BCH(63,56) receive path.
//   BCH_N / BCH_K / BCH_M : code length, message length, parity bits
//   BCH_GPOLY             : generator g(x) = x^7+x^6+x^2+1 (bit 7 implicit)
//   syn_t                 : 7-bit syndrome type
//   state_t               : syndrome front-end state machine encoding
package bch_pkg;

  localparam int BCH_N = 63;
  localparam int BCH_K = 56;
  localparam int BCH_M = 7;

  localparam logic [7:0] BCH_GPOLY = 8'b1100_0101;

  typedef logic [6:0] syn_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bch_syndrome_popcount7.sv
// popcount7: combinational Hamming weight of a 7-bit vector.
//   a   in  7 : input vector
//   cnt out 3 : number of ones in a (0..7)
// Shared with the downstream error-pattern lookup.
module popcount7 (
  input  logic [6:0] a,
  output logic [2:0] cnt
);

  // Sum of the individual bits; 3 bits are enough for a maximum of 7.
  always_comb begin
    cnt = 3'd0;
    for (int i = 0; i < 7; i++) begin
      cnt = cnt + {2'b00, a[i]};
    end
  end

endmodule

// File: rtl/bch_syndrome.sv
// bch_syndrome: serial front end of the BCH(63,56) receiver.
// Deserialises a 63-bit codeword (MSB first) and, in parallel, divides it
// by g(x) to produce the syndrome and its weight for the decoder stage.
//   clk, rst_n   : clock, asynchronous active-low reset
//   din_valid    : qualifies din and frame_start
//   din          : received bit, R[62] first
//   frame_start  : first bit of a codeword
//   R            : captured codeword, held while isEn2=1
//   S            : syndrome R(x) mod g(x)
//   w            : popcount of S
//   isEn2        : level, R/S/w valid until the next accepted frame_start
//   busy         : a frame is being shifted in
module bch_syndrome
  import bch_pkg::*;
#(
  parameter logic [7:0] G_POLY = BCH_GPOLY,
  parameter int         N      = BCH_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         din_valid,
  input  logic         din,
  input  logic         frame_start,
  output logic [N-1:0] R,
  output syn_t         S,
  output logic [2:0]   w,
  output logic         isEn2,
  output logic         busy
);

  localparam logic [5:0] LAST_CNT = 6'(N - 1);

  state_t         state_r, next_state_s;
  logic [N-1:0]   sr_r, next_sr_s;
  syn_t           rem_r, next_rem_s;
  logic [5:0]     cnt_r, next_cnt_s;
  logic [N-1:0]   next_r_s;
  syn_t           next_s_s;
  logic [2:0]     next_w_s;
  logic           next_isen2_s;
  logic           next_busy_s;

  syn_t           rem_shift_s;
  logic [2:0]     rem_weight_s;

  // One LFSR division step: multiply by x, add din, reduce the x^7 term.
  always_comb begin
    rem_shift_s = {rem_r[5:0], din} ^ (rem_r[6] ? G_POLY[6:0] : 7'd0);
  end

  popcount7 u_popcount (
    .a   (rem_shift_s),
    .cnt (rem_weight_s)
  );

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    next_state_s = state_r;
    next_sr_s    = sr_r;
    next_rem_s   = rem_r;
    next_cnt_s   = cnt_r;
    next_r_s     = R;
    next_s_s     = S;
    next_w_s     = w;
    next_isen2_s = isEn2;
    next_busy_s  = busy;

    if (din_valid && frame_start) begin
      // A start bit always begins a fresh frame, from any state.
      next_state_s = SHIFT;
      next_sr_s    = {{(N-1){1'b0}}, din};
      next_rem_s   = {6'b000000, din};
      next_cnt_s   = 6'd1;
      next_isen2_s = 1'b0;
      next_busy_s  = 1'b1;
    end else if (din_valid) begin
      case (state_r)
        SHIFT: begin
          next_sr_s  = {sr_r[N-2:0], din};
          next_rem_s = rem_shift_s;
          if (cnt_r == LAST_CNT) begin
            // Last bit: publish the completed frame on this same edge.
            next_state_s = DONE;
            next_cnt_s   = 6'd0;
            next_r_s     = {sr_r[N-2:0], din};
            next_s_s     = rem_shift_s;
            next_w_s     = rem_weight_s;
            next_isen2_s = 1'b1;
            next_busy_s  = 1'b0;
          end else begin
            next_cnt_s = cnt_r + 6'd1;
          end
        end
        IDLE: begin
          next_state_s = IDLE;
        end
        DONE: begin
          next_state_s = DONE;
        end
        default: begin
          next_state_s = IDLE;
          next_busy_s  = 1'b0;
          next_isen2_s = 1'b0;
        end
      endcase
    end else begin
      // Stall: nothing changes.
      next_state_s = state_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      sr_r    <= '0;
      rem_r   <= 7'd0;
      cnt_r   <= 6'd0;
      R       <= '0;
      S       <= 7'd0;
      w       <= 3'd0;
      isEn2   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_r <= next_state_s;
      sr_r    <= next_sr_s;
      rem_r   <= next_rem_s;
      cnt_r   <= next_cnt_s;
      R       <= next_r_s;
      S       <= next_s_s;
      w       <= next_w_s;
      isEn2   <= next_isen2_s;
      busy    <= next_busy_s;
    end
  end

endmodule

// File: tb/tb_bch_syndrome.sv
module tb_bch_syndrome;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din_valid = 1'b0;
  logic        din = 1'b0;
  logic        frame_start = 1'b0;
  logic [62:0] R;
  logic [6:0]  S;
  logic [2:0]  w;
  logic        isEn2;
  logic        busy;

  int checks = 0;
  int errors = 0;

  bch_syndrome dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din_valid   (din_valid),
    .din         (din),
    .frame_start (frame_start),
    .R           (R),
    .S           (S),
    .w           (w),
    .isEn2       (isEn2),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge; return 1 ns after the rising edge.
  task automatic send_bit(input logic v, input logic fs, input logic b);
    @(negedge clk);
    din_valid   = v;
    frame_start = fs;
    din         = b;
    @(posedge clk);
    #1;
  endtask

  // Shift a full frame in, checking hold/latency behaviour along the way.
  task automatic send_frame(input logic [62:0] r, input bit stall, input logic [62:0] old_r,
                            input logic [6:0] exp_s, input logic [2:0] exp_w, input string tag);
    int n;
    for (int i = 62; i >= 0; i--) begin
      if (stall) begin
        n = $urandom_range(0, 2);
        for (int k = 0; k < n; k++) begin
          send_bit(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
          check({tag, " R held in stall"}, 64'(R), 64'(old_r));
        end
      end
      send_bit(1'b1, (i == 62), r[i]);
      if (i > 0) begin
        check({tag, " isEn2 low mid-frame"}, 64'(isEn2), 64'd0);
        check({tag, " busy mid-frame"}, 64'(busy), 64'd1);
        check({tag, " R held mid-frame"}, 64'(R), 64'(old_r));
      end
    end
    check({tag, " R"}, 64'(R), 64'(r));
    check({tag, " S"}, 64'(S), 64'(exp_s));
    check({tag, " w"}, 64'(w), 64'(exp_w));
    check({tag, " isEn2"}, 64'(isEn2), 64'd1);
    check({tag, " busy done"}, 64'(busy), 64'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " R"}, 64'(R), 64'd0);
    check({tag, " S"}, 64'(S), 64'd0);
    check({tag, " w"}, 64'(w), 64'd0);
    check({tag, " isEn2"}, 64'(isEn2), 64'd0);
    check({tag, " busy"}, 64'(busy), 64'd0);
  endtask

  logic [62:0] partial;

  initial begin
    // Reset state.
    #2;
    check_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Main vectors; expected syndromes are hand-reduced modulo x^7+x^6+x^2+1.
    send_frame(63'h0,   1'b0, 63'h0,   7'h00, 3'd0, "zero");
    send_frame(63'h1,   1'b0, 63'h0,   7'h01, 3'd1, "err_r0");
    send_frame(63'h80,  1'b0, 63'h1,   7'h45, 3'd3, "x7");
    send_frame(63'h7F,  1'b0, 63'h80,  7'h7F, 3'd7, "w_max");
    send_frame(63'h80,  1'b1, 63'h7F,  7'h45, 3'd3, "x7_stall");
    send_frame(63'h100, 1'b0, 63'h80,  7'h4F, 3'd5, "x8");

    // Hold in DONE with idle and stray non-start bits.
    send_bit(1'b0, 1'b1, 1'b1);
    send_bit(1'b1, 1'b0, 1'b1);
    check("done hold isEn2", 64'(isEn2), 64'd1);
    check("done hold S", 64'(S), 64'h4F);

    // Back-to-back frames.
    send_frame(63'h1, 1'b0, 63'h100, 7'h01, 3'd1, "frameA");
    send_frame(63'h0, 1'b0, 63'h1,   7'h00, 3'd0, "frameB");

    // Restart after a 20-bit partial frame.
    partial = 63'h5A5A_1234_F0F0_9999;
    for (int i = 62; i > 42; i--) begin
      send_bit(1'b1, (i == 62), partial[i]);
      check("partial isEn2", 64'(isEn2), 64'd0);
    end
    send_frame(63'h80, 1'b0, 63'h0, 7'h45, 3'd3, "restart");

    // Reset in the middle of a frame.
    for (int i = 62; i > 32; i--) begin
      send_bit(1'b1, (i == 62), partial[i]);
    end
    check("pre-reset R", 64'(R), 64'h80);
    rst_n = 1'b0;
    #1;
    check_zero("mid reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send_bit(1'b1, 1'b0, 1'b1);
    end
    check("stray busy", 64'(busy), 64'd0);
    check("stray isEn2", 64'(isEn2), 64'd0);
    check("stray R", 64'(R), 64'd0);
    send_frame(63'h1, 1'b0, 63'h0, 7'h01, 3'd1, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
